// File: rtl/cond_flag_unit_if.sv
// Bundles the decoder-side requests and the condition-qualified results
// of the ARM condition/flag unit.
interface cond_flag_unit_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       Stall;
  logic       Flush;
  logic       FlagSave;
  logic       FlagRestore;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic       Carry;
  logic [3:0] Flags;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
           Stall, Flush, FlagSave, FlagRestore,
    input  PCSrc, RegWrite, MemWrite, CondEx, Carry, Flags
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
           Stall, Flush, FlagSave, FlagRestore,
    output PCSrc, RegWrite, MemWrite, CondEx, Carry, Flags
  );
endinterface

// File: rtl/cond_flag_unit.sv
// ARM condition check and {N,Z,C,V} flag register with a one-deep shadow
// copy for save/restore; write enables are gated by the condition result.
module cond_flag_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic            CLK,
  input  logic            RESET,
  cond_flag_unit_if.slave bus
);

  logic [3:0] r_flags;
  logic [3:0] r_shadow;
  logic [3:0] w_flags_upd;
  logic [3:0] w_flags_nxt;
  logic       w_cond_ex;
  logic       w_go;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic res;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = c;
      4'b0011: res = ~c;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = c & ~z;
      4'b1001: res = ~c | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = z | (n != v);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  // Condition is always evaluated against the registered (pre-update) flags.
  assign w_cond_ex = cond_pass(bus.Cond, r_flags);
  assign w_go      = w_cond_ex & ~bus.Flush & ~bus.Stall;

  assign bus.CondEx   = w_cond_ex;
  assign bus.PCSrc    = bus.PCS & w_go;
  assign bus.RegWrite = bus.RegW & ~bus.NoWrite & w_go;
  assign bus.MemWrite = bus.MemW & w_go;
  assign bus.Flags    = r_flags;
  assign bus.Carry    = r_flags[1];

  always_comb begin
    w_flags_upd = r_flags;
    if (bus.FlagW[1]) w_flags_upd[3:2] = bus.ALUFlags[3:2];
    if (bus.FlagW[0]) w_flags_upd[1:0] = bus.ALUFlags[1:0];

    // Restore bypasses Stall/Flush and beats any ALU update on the same edge.
    w_flags_nxt = r_flags;
    if (bus.FlagRestore) w_flags_nxt = r_shadow;
    else if (w_go)       w_flags_nxt = w_flags_upd;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_flags  <= RESET_FLAGS;
      r_shadow <= RESET_FLAGS;
    end else begin
      r_flags <= w_flags_nxt;
      if (bus.FlagSave) r_shadow <= r_flags;
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit: directed scenarios plus a
// randomized run against a behavioural flag/shadow model.
module tb_cond_flag_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [3:0] m_flags;
  logic [3:0] m_shadow;

  cond_flag_unit_if bus ();

  cond_flag_unit #(.RESET_FLAGS(4'b0000)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Condition pass from the ARM mnemonic meaning of each code.
  function automatic logic ref_pass(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return c && !z;
      9:  return !c || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic ref_go();
    return ref_pass(bus.Cond, m_flags) && !bus.Flush && !bus.Stall;
  endfunction

  task automatic idle();
    bus.Cond = 4'b1110; bus.ALUFlags = 4'b0000; bus.FlagW = 2'b00;
    bus.PCS = 0; bus.RegW = 0; bus.MemW = 0; bus.NoWrite = 0;
    bus.Stall = 0; bus.Flush = 0; bus.FlagSave = 0; bus.FlagRestore = 0;
  endtask

  // Advance one clock edge and move the model with the inputs seen at that edge.
  task automatic tick();
    logic [3:0] nf, ns;
    if (rst) begin
      nf = 4'b0000;
      ns = 4'b0000;
    end else begin
      ns = bus.FlagSave ? m_flags : m_shadow;
      nf = m_flags;
      if (bus.FlagRestore) nf = m_shadow;
      else if (ref_go()) begin
        if (bus.FlagW[1]) nf[3:2] = bus.ALUFlags[3:2];
        if (bus.FlagW[0]) nf[1:0] = bus.ALUFlags[1:0];
      end
    end
    @(posedge clk);
    #1;
    m_flags  = nf;
    m_shadow = ns;
  endtask

  // Load flags through a normal unconditional ALU update.
  task automatic load_flags(input logic [3:0] f);
    idle();
    bus.FlagW = 2'b11; bus.ALUFlags = f;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    bus.FlagSave = 1; bus.FlagRestore = 1; bus.FlagW = 2'b11; bus.ALUFlags = 4'b1111;
    tick();
    tick();
    #1;
    checks++;
    if (bus.Flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", bus.Flags); end
    bus.Cond = 4'b0000; #1;
    checks++;
    if (bus.CondEx !== 1'b0) begin errors++; $display("FAIL reset_eq got %b want 0", bus.CondEx); end
    bus.Cond = 4'b0001; #1;
    checks++;
    if (bus.CondEx !== 1'b1 || bus.Carry !== 1'b0) begin
      errors++; $display("FAIL reset_ne_carry got ne=%b c=%b want ne=1 c=0", bus.CondEx, bus.Carry);
    end
    rst = 0;
    idle();
    tick();
  endtask

  task automatic test_cond_gating();
    idle();
    bus.Cond = 4'b0000; bus.RegW = 1; #1;
    checks++;
    if (bus.CondEx !== 1'b0 || bus.RegWrite !== 1'b0) begin
      errors++; $display("FAIL eq_gate got condex=%b regwrite=%b want 0 0", bus.CondEx, bus.RegWrite);
    end
    bus.Cond = 4'b1110; #1;
    checks++;
    if (bus.RegWrite !== 1'b1) begin errors++; $display("FAIL al_regwrite got %b want 1", bus.RegWrite); end
    bus.NoWrite = 1; bus.PCS = 1; bus.MemW = 1; #1;
    checks++;
    if ({bus.RegWrite, bus.PCSrc, bus.MemWrite} !== 3'b011) begin
      errors++; $display("FAIL nowrite got %b want 011", {bus.RegWrite, bus.PCSrc, bus.MemWrite});
    end
    idle();
  endtask

  task automatic test_flag_update();
    load_flags(4'b0100);
    bus.Cond = 4'b0000; #1;
    checks++;
    if (bus.Flags !== 4'b0100 || bus.CondEx !== 1'b1 || bus.Carry !== 1'b0) begin
      errors++; $display("FAIL upd_nz got flags=%b eq=%b c=%b want 0100 1 0", bus.Flags, bus.CondEx, bus.Carry);
    end
    idle();
    bus.FlagW = 2'b01; bus.ALUFlags = 4'b1011;
    tick();
    idle();
    checks++;
    if (bus.Flags !== 4'b0111 || bus.Carry !== 1'b1) begin
      errors++; $display("FAIL upd_cv got flags=%b c=%b want 0111 1", bus.Flags, bus.Carry);
    end
    bus.ALUFlags = 4'b0000; #1;
    checks++;
    if (bus.Carry !== 1'b1) begin errors++; $display("FAIL carry_comb got %b want 1", bus.Carry); end
    bus.FlagW = 2'b10; bus.ALUFlags = 4'b1000;
    tick();
    idle();
    checks++;
    if (bus.Flags !== 4'b1011) begin errors++; $display("FAIL upd_nz_only got %b want 1011", bus.Flags); end
  endtask

  task automatic test_signed_conds();
    load_flags(4'b1000);
    bus.Cond = 4'b1011; #1;
    checks++;
    if (bus.CondEx !== 1'b1) begin errors++; $display("FAIL lt got %b want 1", bus.CondEx); end
    bus.Cond = 4'b1010; #1;
    checks++;
    if (bus.CondEx !== 1'b0) begin errors++; $display("FAIL ge got %b want 0", bus.CondEx); end
    bus.Cond = 4'b1100; #1;
    checks++;
    if (bus.CondEx !== 1'b0) begin errors++; $display("FAIL gt_a got %b want 0", bus.CondEx); end
    load_flags(4'b1001);
    bus.Cond = 4'b1100; #1;
    checks++;
    if (bus.CondEx !== 1'b1) begin errors++; $display("FAIL gt_b got %b want 1", bus.CondEx); end
    bus.Cond = 4'b1101; #1;
    checks++;
    if (bus.CondEx !== 1'b0) begin errors++; $display("FAIL le got %b want 0", bus.CondEx); end
    // Failed condition must not write flags.
    bus.Cond = 4'b0000; bus.FlagW = 2'b11; bus.ALUFlags = 4'b0110;
    tick();
    idle();
    checks++;
    if (bus.Flags !== 4'b1001) begin errors++; $display("FAIL condfail_hold got %b want 1001", bus.Flags); end
    for (int c = 0; c < 16; c++) begin
      bus.Cond = 4'(c); #1;
      checks++;
      if (bus.CondEx !== ref_pass(4'(c), 4'b1001)) begin
        errors++; $display("FAIL cond_table[%0d] got %b want %b", c, bus.CondEx, ref_pass(4'(c), 4'b1001));
      end
    end
    idle();
  endtask

  task automatic test_stall();
    load_flags(4'b0001);
    bus.Stall = 1; bus.FlagW = 2'b11; bus.ALUFlags = 4'b1111;
    bus.PCS = 1; bus.RegW = 1; bus.MemW = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus.PCSrc, bus.RegWrite, bus.MemWrite} !== 3'b000 || bus.Flags !== 4'b0001) begin
        errors++; $display("FAIL stall[%0d] got we=%b flags=%b want 000 0001", i,
                           {bus.PCSrc, bus.RegWrite, bus.MemWrite}, bus.Flags);
      end
      tick();
    end
    bus.Stall = 0; #1;
    checks++;
    if ({bus.PCSrc, bus.RegWrite, bus.MemWrite} !== 3'b111) begin
      errors++; $display("FAIL stall_release_we got %b want 111", {bus.PCSrc, bus.RegWrite, bus.MemWrite});
    end
    tick();
    idle();
    checks++;
    if (bus.Flags !== 4'b1111) begin errors++; $display("FAIL stall_release got %b want 1111", bus.Flags); end
    bus.Flush = 1; bus.FlagW = 2'b11; bus.ALUFlags = 4'b0000; bus.PCS = 1;
    #1;
    checks++;
    if (bus.PCSrc !== 1'b0) begin errors++; $display("FAIL flush_we got %b want 0", bus.PCSrc); end
    tick();
    idle();
    checks++;
    if (bus.Flags !== 4'b1111) begin errors++; $display("FAIL flush_hold got %b want 1111", bus.Flags); end
  endtask

  task automatic test_save_restore();
    load_flags(4'b0010);
    bus.FlagSave = 1;
    tick();
    load_flags(4'b1100);
    bus.FlagRestore = 1; bus.FlagW = 2'b11; bus.ALUFlags = 4'b0001;
    tick();
    idle();
    checks++;
    if (bus.Flags !== 4'b0010) begin errors++; $display("FAIL restore_wins got %b want 0010", bus.Flags); end
    load_flags(4'b1100);
    bus.FlagRestore = 1; bus.Stall = 1; bus.Flush = 1;
    tick();
    idle();
    checks++;
    if (bus.Flags !== 4'b0010) begin errors++; $display("FAIL restore_stalled got %b want 0010", bus.Flags); end
  endtask

  task automatic test_swap_reset();
    load_flags(4'b0101);
    bus.FlagSave = 1;
    tick();
    load_flags(4'b1010);
    bus.FlagSave = 1; bus.FlagRestore = 1;
    tick();
    idle();
    checks++;
    if (bus.Flags !== 4'b0101) begin errors++; $display("FAIL swap_flags got %b want 0101", bus.Flags); end
    bus.FlagRestore = 1;
    tick();
    idle();
    checks++;
    if (bus.Flags !== 4'b1010) begin errors++; $display("FAIL swap_shadow got %b want 1010", bus.Flags); end
    rst = 1; bus.FlagRestore = 1;
    tick();
    rst = 0;
    idle();
    checks++;
    if (bus.Flags !== 4'b0000) begin errors++; $display("FAIL reset_over_restore got %b want 0000", bus.Flags); end
    load_flags(4'b1111);
    bus.FlagRestore = 1;
    tick();
    idle();
    checks++;
    if (bus.Flags !== 4'b0000) begin errors++; $display("FAIL reset_shadow got %b want 0000", bus.Flags); end
  endtask

  task automatic test_random();
    logic go;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 31) == 0);
      bus.Cond = 4'($urandom); bus.ALUFlags = 4'($urandom); bus.FlagW = 2'($urandom);
      bus.PCS = 1'($urandom); bus.RegW = 1'($urandom); bus.MemW = 1'($urandom);
      bus.NoWrite = 1'($urandom);
      bus.Stall = ($urandom_range(0, 3) == 0);
      bus.Flush = ($urandom_range(0, 5) == 0);
      bus.FlagSave = ($urandom_range(0, 5) == 0);
      bus.FlagRestore = ($urandom_range(0, 5) == 0);
      #1;
      go = ref_go();
      checks++;
      if (bus.Flags !== m_flags || bus.Carry !== m_flags[1] ||
          bus.CondEx !== ref_pass(bus.Cond, m_flags) ||
          bus.PCSrc !== (bus.PCS & go) ||
          bus.RegWrite !== (bus.RegW & ~bus.NoWrite & go) ||
          bus.MemWrite !== (bus.MemW & go)) begin
        errors++;
        $display("FAIL random[%0d] got flags=%b cx=%b we=%b%b%b want flags=%b cx=%b go=%b", i,
                 bus.Flags, bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite,
                 m_flags, ref_pass(bus.Cond, m_flags), go);
      end
      tick();
    end
    rst = 0;
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 0;
    m_flags = 4'bxxxx;
    m_shadow = 4'bxxxx;
    idle();
    test_reset();
    test_cond_gating();
    test_flag_update();
    test_signed_conds();
    test_stall();
    test_save_restore();
    test_swap_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
